// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-port AXI read arbiter.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAr   = 2'd1,
    StR    = 2'd2
  } state_e;

  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // Clear the in-line offset bits so a cached refill starts at the line base.
  function automatic logic [31:0] line_align(input logic [31:0] addr,
                                             input int unsigned line_bytes);
    return addr & ~(line_bytes[31:0] - 32'd1);
  endfunction

endpackage

// File: rtl/axi_rd_grant.sv
// Two-request grant selector. Fixed data-over-inst priority by default;
// AXI_RD_ARB_RR_EN enables round-robin with a one-bit last-grant register.
module axi_rd_grant
  import axi_rd_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inst_req_i,
  input  logic data_req_i,
  input  logic take_i,
  output logic valid_o,
  output logic owner_o
);

  assign valid_o = inst_req_i | data_req_i;

`ifdef AXI_RD_ARB_RR_EN
  logic last_q;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    owner_o = data_req_i ? OWN_DATA : OWN_INST;
    if (inst_req_i && data_req_i) begin
      owner_o = ~last_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= OWN_INST;
    end else if (take_i) begin
      last_q <= owner_o;
    end
  end
`else
  logic unused_grant;
  assign unused_grant = ^{clk_i, rst_ni, take_i, inst_req_i};

  always_comb begin
    owner_o = data_req_i ? OWN_DATA : OWN_INST;
  end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between inst and data cache refill ports,
// one burst at a time. Optional round-robin via AXI_RD_ARB_RR_EN.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8,
  parameter logic [3:0]  INST_ID    = 4'd0,
  parameter logic [3:0]  DATA_ID    = 4'd1
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_uncached,
  output logic        inst_addr_ok,
  output logic        inst_beat_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_uncached,
  output logic        data_addr_ok,
  output logic        data_beat_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned LineBytes = LINE_WORDS * 4;

  state_e      state_q;
  logic        owner_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic [3:0]  arid_q;
  logic        arvalid_q;
  logic        rready_q;

  logic        gnt_valid;
  logic        gnt_owner;
  logic        take;
  logic [31:0] sel_addr;
  logic        sel_unc;

  logic unused_rbus;
  assign unused_rbus = ^{rid, rresp};

  assign take = (state_q == StIdle) && gnt_valid;

  axi_rd_grant u_grant (
    .clk_i      (cpu_clk_50M),
    .rst_ni     (cpu_rst_n),
    .inst_req_i (inst_req),
    .data_req_i (data_req),
    .take_i     (take),
    .valid_o    (gnt_valid),
    .owner_o    (gnt_owner)
  );

  assign sel_addr = (gnt_owner == OWN_DATA) ? data_addr : inst_addr;
  assign sel_unc  = (gnt_owner == OWN_DATA) ? data_uncached : inst_uncached;

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q   <= StIdle;
      owner_q   <= OWN_INST;
      araddr_q  <= 32'd0;
      arlen_q   <= 8'd0;
      arid_q    <= 4'd0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            owner_q   <= gnt_owner;
            araddr_q  <= sel_unc ? sel_addr : line_align(sel_addr, LineBytes);
            arlen_q   <= sel_unc ? 8'd0 : 8'(LINE_WORDS - 1);
            arid_q    <= (gnt_owner == OWN_DATA) ? DATA_ID : INST_ID;
            arvalid_q <= 1'b1;
            state_q   <= StAr;
          end
        end
        StAr: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StR;
          end
        end
        StR: begin
          // rlast alone terminates the burst; beat count is not tracked.
          if (rvalid && rlast) begin
            rready_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  logic addr_hs;
  logic beat;

  assign addr_hs = arvalid_q && arready;
  assign beat    = (state_q == StR) && rvalid;

  assign inst_addr_ok = addr_hs && (owner_q == OWN_INST);
  assign data_addr_ok = addr_hs && (owner_q == OWN_DATA);
  assign inst_beat_ok = beat && (owner_q == OWN_INST);
  assign data_beat_ok = beat && (owner_q == OWN_DATA);
  assign inst_data_ok = inst_beat_ok && rlast;
  assign data_data_ok = data_beat_ok && rlast;
  assign inst_rdata   = inst_beat_ok ? rdata : 32'd0;
  assign data_rdata   = data_beat_ok ? rdata : 32'd0;

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign arsize  = SIZE_WORD;
  assign arburst = BURST_INCR;
  assign arlock  = 1'b0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

endmodule
